// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared constants and receiver state encoding for uart_rx_fifo.
package uart_rx_fifo_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    localparam int OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE = 4'd7;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// uart_fifo_sync: first-word-fall-through FIFO with occupancy count and sticky overrun.
module uart_fifo_sync #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_cnt, rd_cnt;
    logic do_push, do_pop;
    assign level   = wr_cnt - rd_cnt;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a pop frees the slot for a simultaneous push even when full
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_cnt[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + 1'b1;
            if (do_pop) rd_cnt <= rd_cnt + 1'b1;
            overrun <= (push & ~do_push) | (overrun & ~clr_err);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_cnt[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver with configurable framing,
// per-word error flags and a FWFT receive FIFO.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 125000000,
    parameter int UART_FREQUENCY = 9600,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          data,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          valid,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun
);
    localparam int DIV = CLK_FREQUENCY / (UART_FREQUENCY * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    logic rx_m, rx_s, rx_d, push, par_err, frm_err, empty, tick, fall, mid;
    logic [DW-1:0] div_cnt;
    logic [3:0] os_cnt, bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS+1:0] word, head;
    rx_state_t state;
    assign tick = div_cnt == DW'(DIV - 1);
    assign fall = rx_d & ~rx_s;
    assign mid  = tick & (os_cnt == MID_SAMPLE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_d, rx_s, rx_m} <= '1;
            state   <= S_IDLE;
            div_cnt <= '0;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            push    <= 1'b0;
            word    <= '0;
        end else begin
            {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
            push    <= 1'b0;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (state != S_IDLE && tick) os_cnt <= os_cnt + 1'b1;
            case (state)
                // restarting the divider here centres every later sample on its bit
                S_IDLE: if (fall) begin
                    state   <= S_START;
                    div_cnt <= '0;
                    os_cnt  <= '0;
                end
                S_START: if (mid) begin
                    state   <= rx_s ? S_IDLE : S_DATA;
                    bit_cnt <= '0;
                    frm_err <= 1'b0;
                    par_err <= 1'b0;
                end
                S_DATA: if (mid) begin
                    shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state   <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                        bit_cnt <= '0;
                    end
                end
                S_PARITY: if (mid) begin
                    par_err <= (PARITY == PARITY_EVEN) ? ^{shreg, rx_s} : ~^{shreg, rx_s};
                    state   <= S_STOP;
                end
                S_STOP: if (mid) begin
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        push  <= 1'b1;
                        word  <= {par_err, frm_err | ~rx_s, shreg};
                        state <= S_IDLE;
                    end else begin
                        frm_err <= frm_err | ~rx_s;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    uart_fifo_sync #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .wdata(word), .pop(rd_en),
        .clr_err(clr_err), .rdata(head), .full(full), .empty(empty),
        .level(level), .overrun(overrun)
    );
    assign data       = head[DATA_BITS-1:0];
    assign frame_err  = head[DATA_BITS];
    assign parity_err = head[DATA_BITS+1];
    assign valid      = ~empty;
endmodule
